mmio_keypad_io: RTL

Parametrised memory-mapped I/O block for the processor's data bus, replacing the fixed display stub. It holds the seven-segment and LED output registers, debounces a configurable number of raw key inputs and latches key-press events in a write-1-to-clear register. It raises a maskable interrupt request, so software no longer needs to poll for presses. It sits on the same single-cycle load/store path as data memory and is selected by address decode inside the block.

---
 rtl/io_pkg.sv | 21 ++
 rtl/io_key_debounce.sv | 71 +++++++
 rtl/mmio_keypad_io.sv | 102 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped keypad/display I/O block.
// Holds register offsets (relative to BASE_ADDR) and the register-select
// enum produced by the address decoder.
package io_pkg;

  localparam logic [31:0] SEGMENTS_OFS   = 32'h00;
  localparam logic [31:0] LIGHTS_OFS     = 32'h04;
  localparam logic [31:0] KEYS_OFS       = 32'h08;
  localparam logic [31:0] KEY_EVENTS_OFS = 32'h0C;
  localparam logic [31:0] IRQ_MASK_OFS   = 32'h10;

  typedef enum logic [2:0] {
    SelNone,
    SelSegments,
    SelLights,
    SelKeys,
    SelKeyEvents,
    SelIrqMask
  } reg_sel_e;

endpackage

// File: rtl/io_key_debounce.sv
// Per-key input conditioning: 2-flop synchroniser followed by a debouncer.
// Optional feature macro: IO_DEBOUNCE_EN
//   defined   - counter debouncer; a change at the synchroniser output must be
//               stable for DEBOUNCE_CYCLES cycles before the level follows it.
//   undefined - no counter; the level simply follows the synchroniser output.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset
//   raw    - asynchronous key level, 1 = pressed
//   level  - next-state of the debounced level; the parent registers it so it
//            can see the 0->1 transition on the same edge it is stored.
module io_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);
  import io_pkg::*;

  logic sync1_q, sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      // Reaching DEBOUNCE_CYCLES toggles the level and restarts the count.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign level = deb_d;
`else
  // The parent's register on level forms the third flop.
  logic unused_cfg;
  assign unused_cfg = ^DEBOUNCE_CYCLES;
  assign level      = sync2_q;
`endif

endmodule

// File: rtl/mmio_keypad_io.sv
// Memory-mapped I/O block: seven-segment and LED output registers, debounced
// key inputs, sticky write-1-to-clear press events and a maskable interrupt.
// Optional feature macro: IO_DEBOUNCE_EN (enables the counter debouncer).
// Ports:
//   clock, reset  - system clock, asynchronous active-high reset
//   write_enable  - store strobe, qualified by address
//   address       - byte address, full 32-bit decode
//   write_data    - store data
//   read_data     - combinational load data
//   keys_raw      - asynchronous key levels, 1 = pressed
//   segments      - SEGMENTS register
//   lights        - LIGHTS register
//   irq           - |(KEY_EVENTS & IRQ_MASK)
module mmio_keypad_io
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h8000,
  parameter int unsigned NUM_KEYS        = 8,
  parameter int unsigned NUM_LIGHTS      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  input  logic [NUM_KEYS-1:0]   keys_raw,
  output logic [31:0]           segments,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  irq
);

  reg_sel_e sel;

  logic [31:0]           segments_q;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [NUM_KEYS-1:0]   keys_q, keys_d;
  logic [NUM_KEYS-1:0]   events_q, events_d;
  logic [NUM_KEYS-1:0]   mask_q;
  logic [NUM_KEYS-1:0]   clr_bits;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    io_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .raw  (keys_raw[i]),
      .level(keys_d[i])
    );
  end

  always_comb begin
    sel = SelNone;
    if (address == BASE_ADDR + SEGMENTS_OFS)        sel = SelSegments;
    else if (address == BASE_ADDR + LIGHTS_OFS)     sel = SelLights;
    else if (address == BASE_ADDR + KEYS_OFS)       sel = SelKeys;
    else if (address == BASE_ADDR + KEY_EVENTS_OFS) sel = SelKeyEvents;
    else if (address == BASE_ADDR + IRQ_MASK_OFS)   sel = SelIrqMask;
  end

  // A press on the same edge as a clearing write wins.
  always_comb begin
    clr_bits = '0;
    if (write_enable && sel == SelKeyEvents) clr_bits = write_data[NUM_KEYS-1:0];
    events_d = (events_q & ~clr_bits) | (keys_d & ~keys_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      segments_q <= '0;
      lights_q   <= '0;
      keys_q     <= '0;
      events_q   <= '0;
      mask_q     <= '0;
    end else begin
      if (write_enable && sel == SelSegments) segments_q <= write_data;
      if (write_enable && sel == SelLights)   lights_q   <= write_data[NUM_LIGHTS-1:0];
      if (write_enable && sel == SelIrqMask)  mask_q     <= write_data[NUM_KEYS-1:0];
      keys_q   <= keys_d;
      events_q <= events_d;
    end
  end

  always_comb begin
    read_data = '0;
    unique case (sel)
      SelSegments:  read_data = segments_q;
      SelLights:    read_data[NUM_LIGHTS-1:0] = lights_q;
      SelKeys:      read_data[NUM_KEYS-1:0] = keys_q;
      SelKeyEvents: read_data[NUM_KEYS-1:0] = events_q;
      SelIrqMask:   read_data[NUM_KEYS-1:0] = mask_q;
      default:      read_data = '0;
    endcase
  end

  assign segments = segments_q;
  assign lights   = lights_q;
  assign irq      = |(events_q & mask_q);

endmodule
